// File: rtl/scaler_video_out.sv
// -----------------------------------------------------------------------------
// scaler_video_out
//
// Output-side receiver for the grayscale scaler's pixel stream. Pixels arrive
// on a tvsync/tvalid/tdata interface with no backpressure, are buffered in a
// dual-port FIFO and are re-timed into a continuous display raster
// (hsync/vsync/de + data). The block locks to the stream at frame start: after
// tvsync_i it arms, collects the first pixels, and once START_LEVEL pixels
// are buffered the raster counters start. Any overflow (pixel dropped on a
// full FIFO) or underflow (active pixel with an empty FIFO) schedules a
// relock, taken at the next frame boundary so the current raster stays whole.
//
// Ports
//   clk_i        pixel clock (same domain as the scaler)
//   rst_i        synchronous active-high reset
//   tvsync_i     scaler frame marker, high between frames
//   tvalid_i     pixel valid (cannot be stalled)
//   tdata_i      pixel data
//   hsync_o      horizontal sync, active high
//   vsync_o      vertical sync, active high
//   de_o         data enable (active region)
//   data_o       pixel out, 0 whenever de_o = 0
//   locked_o     raster running from the stream
//   overflow_o   sticky: a pixel was dropped on a full FIFO
//   underflow_o  sticky: de_o was asserted with an empty FIFO
// -----------------------------------------------------------------------------
module scaler_video_out #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 2048,
  parameter int START_LEVEL = 800,
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 40,
  parameter int H_SYNC      = 128,
  parameter int H_BP        = 88,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 23
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tvsync_i,
  input  logic                  tvalid_i,
  input  logic [DATA_WIDTH-1:0] tdata_i,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  locked_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  // One spare value so window end points equal to the total still fit.
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] FILL_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FILL_START = CW'(START_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           fill_q, fill_d;
  logic [HW-1:0]           h_cnt_q, h_cnt_d;
  logic [VW-1:0]           v_cnt_q, v_cnt_d;
  logic                    relock_q, relock_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    hsync_q, hsync_d;
  logic                    vsync_q, vsync_d;
  logic                    de_q, de_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];

  logic active, hs_win, vs_win, h_wrap, v_wrap;
  logic fifo_empty, fifo_full, running, accepting;
  logic rd_en, wr_en, ovf_evt, unf_evt, out_en;

  // Raster decode and FIFO handshake from the current counters and fill.
  always_comb begin
    active     = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    hs_win     = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_win     = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    h_wrap     = (h_cnt_q == H_LAST);
    v_wrap     = h_wrap && (v_cnt_q == V_LAST);
    fifo_empty = (fill_q == '0);
    fifo_full  = (fill_q == FILL_FULL);
    running    = (state_q == ST_RUN);
    accepting  = (state_q != ST_IDLE);
    rd_en      = running && active && !fifo_empty;
    // A read in the same cycle frees a slot, so a full FIFO still accepts.
    wr_en      = accepting && tvalid_i && (!fifo_full || rd_en);
    ovf_evt    = accepting && tvalid_i && fifo_full && !rd_en;
    unf_evt    = running && active && fifo_empty;
  end

  // Lock state machine: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (tvsync_i) state_d = ST_ARM;
      ST_ARM:  if (fill_q >= FILL_START) state_d = ST_RUN;
      // Errors are only acted on at the frame boundary to keep the raster whole.
      ST_RUN:  if (v_wrap && (relock_q || ovf_evt || unf_evt)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointers and fill level; leaving for (or staying in) IDLE flushes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    if (state_d == ST_IDLE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end
  end

  // Raster counters free-run only while RUN persists; they sit at 0 otherwise,
  // so entering RUN always starts the raster at pixel (0,0).
  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (running && (state_d == ST_RUN)) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Output stage: one register from counter decode to pins, all outputs aligned.
  always_comb begin
    out_en   = running && (state_d == ST_RUN);
    hsync_d  = out_en && hs_win;
    vsync_d  = out_en && vs_win;
    de_d     = out_en && active;
    // Underflow keeps de asserted but drives black.
    data_d   = (out_en && rd_en) ? mem_q[rd_ptr_q] : '0;
    ovf_d    = ovf_q | ovf_evt;
    unf_d    = unf_q | unf_evt;
    relock_d = (state_d == ST_IDLE) ? 1'b0 : (relock_q | ovf_evt | unf_evt);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      relock_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      de_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      relock_q <= relock_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      data_q   <= data_d;
    end
  end

  // Pixel storage: no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= tdata_i;
  end

  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign de_o        = de_q;
  assign data_o      = data_q;
  assign locked_o    = (state_q == ST_RUN);
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_scaler_video_out.sv
// -----------------------------------------------------------------------------
// tb_scaler_video_out
//
// Bench for scaler_video_out with a small raster (8+2+2+2 by 4+1+1+1) and a
// 16-entry FIFO. Instance A uses START_LEVEL=8; instance B uses START_LEVEL=16
// for the overflow case. Expected pixels are queued as they are driven and
// popped by per-instance monitors whenever de is high.
// -----------------------------------------------------------------------------
module tb_scaler_video_out;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          tvsync, tvalid;
  logic [DW-1:0] tdata;
  logic          hsync, vsync, de, locked, ovf, unf;
  logic [DW-1:0] dout;
  logic          b_tvsync, b_tvalid;
  logic [DW-1:0] b_tdata;
  logic          b_hsync, b_vsync, b_de, b_locked, b_ovf, b_unf;
  logic [DW-1:0] b_dout;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  scaler_video_out #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(16), .START_LEVEL(8),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .tvsync_i(tvsync), .tvalid_i(tvalid), .tdata_i(tdata),
    .hsync_o(hsync), .vsync_o(vsync), .de_o(de), .data_o(dout),
    .locked_o(locked), .overflow_o(ovf), .underflow_o(unf)
  );

  scaler_video_out #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(16), .START_LEVEL(16),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .tvsync_i(b_tvsync), .tvalid_i(b_tvalid), .tdata_i(b_tdata),
    .hsync_o(b_hsync), .vsync_o(b_vsync), .de_o(b_de), .data_o(b_dout),
    .locked_o(b_locked), .overflow_o(b_ovf), .underflow_o(b_unf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_b[$];
  bit mon_en = 1'b0;
  bit rec_en = 1'b0;
  int de_r[$], de_f[$], hs_r[$], hs_f[$], vs_r[$], vs_f[$], lk_r[$];
  logic de_p = 1'b0, hs_p = 1'b0, vs_p = 1'b0, lk_p = 1'b0;

  // Monitor A: scoreboard pop on de, blanking rules, edge timestamps.
  always @(negedge clk) begin
    if (mon_en) begin
      if (de) begin
        check("a_de_has_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("a_data", dout, exp_q.pop_front());
      end else begin
        check("a_data_blank", dout, 0);
      end
      if (!locked) check("a_sync_unlocked", {hsync, vsync, de}, 0);
      if (rec_en) begin
        if (de && !de_p)        de_r.push_back(cyc);
        if (!de && de_p)        de_f.push_back(cyc);
        if (hsync && !hs_p)     hs_r.push_back(cyc);
        if (!hsync && hs_p)     hs_f.push_back(cyc);
        if (vsync && !vs_p)     vs_r.push_back(cyc);
        if (!vsync && vs_p)     vs_f.push_back(cyc);
        if (locked && !lk_p)    lk_r.push_back(cyc);
      end
    end
    de_p <= de;
    hs_p <= hsync;
    vs_p <= vsync;
    lk_p <= locked;
  end

  // Monitor B.
  always @(negedge clk) begin
    if (mon_en) begin
      if (b_de) begin
        check("b_de_has_expected", exp_b.size() > 0, 1);
        if (exp_b.size() > 0) check("b_data", b_dout, exp_b.pop_front());
      end else begin
        check("b_data_blank", b_dout, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d);
    tvalid = v;
    tdata  = v ? d : '0;
    if (v) exp_q.push_back(d);
  endtask

  task automatic arm_a();
    tick(); tvsync = 1'b1;
    tick(); tvsync = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  int s, t, pos, ln, h, d;
  bit v;

  initial begin
    rst = 1'b1;
    tvsync = 1'b0; tvalid = 1'b0; tdata = '0;
    b_tvsync = 1'b0; b_tvalid = 1'b0; b_tdata = '0;

    // 1. Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      tvsync = 1'($urandom); tvalid = 1'($urandom); tdata = 8'($urandom);
      b_tvsync = 1'($urandom); b_tvalid = 1'($urandom); b_tdata = 8'($urandom);
      @(negedge clk);
      check("rst_hsync", hsync, 0);
      check("rst_vsync", vsync, 0);
      check("rst_de", de, 0);
      check("rst_data", dout, 0);
      check("rst_locked", locked, 0);
      check("rst_ovf", ovf, 0);
      check("rst_unf", unf, 0);
      check("rst_b_locked", b_locked, 0);
    end
    tvsync = 1'b0; tvalid = 1'b0; tdata = '0;
    b_tvsync = 1'b0; b_tvalid = 1'b0; b_tdata = '0;
    rst = 1'b0;
    mon_en = 1'b1;

    // 2/3. Burst of 32 pixels, then two frames at raster rate.
    rec_en = 1'b1;
    arm_a();
    s = cyc;
    for (int c = 0; c < 294; c++) begin
      if (c < 32) begin
        v = 1'b1; d = c;
      end else if (c < 98) begin
        v = 1'b0; d = 0;
      end else begin
        pos = (c - 98) % 98; ln = pos / 14; h = pos % 14;
        v = (ln < 4) && (h < 8);
        d = 32 + ((c - 98) / 98) * 32 + ln * 8 + h;
      end
      drive(v, 8'(d));
      tick();
    end
    drive(1'b0, '0);
    rec_en = 1'b0;
    check("t2_lock_rise", at(lk_r, 0) - s, 9);
    check("t2_de_rise", at(de_r, 0) - s, 10);
    check("t2_de_fall", at(de_f, 0) - s, 18);
    check("t2_hs_rise", at(hs_r, 0) - s, 20);
    check("t2_hs_fall", at(hs_f, 0) - s, 22);
    check("t3_line3_de", at(de_r, 3) - s, 52);
    check("t3_frame2_de", at(de_r, 4) - s, 108);
    check("t3_de_lines", de_r.size(), 12);
    check("t3_vs_rise", at(vs_r, 0) - s, 80);
    check("t3_vs_width", at(vs_f, 0) - at(vs_r, 0), 14);
    check("t3_vs_period", at(vs_r, 1) - at(vs_r, 0), 98);
    check("t3_vs_count", vs_r.size(), 3);
    check("t3_hs_count", hs_r.size(), 20);
    check("t3_queue_drained", exp_q.size(), 0);
    check("t3_no_ovf", ovf, 0);
    check("t3_no_unf", unf, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    exp_q.delete();

    // 4. Underflow: only 12 pixels, then relock.
    arm_a();
    s = cyc;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 8'(200 + c));
      tick();
    end
    drive(1'b0, '0);
    repeat (20) exp_q.push_back('0);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!locked) begin
        t = cyc;
        break;
      end
    end
    check("t4_lock_drop", t - s, 107);
    check("t4_unf", unf, 1);
    check("t4_no_ovf", ovf, 0);
    check("t4_queue_drained", exp_q.size(), 0);
    arm_a();
    s = cyc;
    for (int c = 0; c < 32; c++) begin
      drive(1'b1, 8'(50 + c));
      tick();
    end
    drive(1'b0, '0);

    // 6. Reset in line 2 of the relocked frame.
    while (cyc < s + 40) tick();
    @(negedge clk);
    check("t6_relocked", locked, 1);
    check("t6_mid_line_de", de, 1);
    check("t4_unf_sticky", unf, 1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_rst_de", de, 0);
    check("t6_rst_data", dout, 0);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_unf_clear", unf, 0);
    arm_a();
    for (int c = 0; c < 32; c++) begin
      drive(1'b1, 8'(150 + c));
      tick();
    end
    drive(1'b0, '0);
    t = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        t = 1;
        break;
      end
    end
    check("t6_drain_in_time", t, 1);
    check("t6_no_unf", unf, 0);
    check("t6_no_ovf", ovf, 0);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    exp_q.delete();

    // 5. Overflow on instance B (START_LEVEL=16): 17th pixel dropped.
    tick(); b_tvsync = 1'b1;
    tick(); b_tvsync = 1'b0;
    s = cyc;
    for (int c = 0; c < 17; c++) begin
      b_tvalid = 1'b1;
      b_tdata  = 8'(c);
      if (c < 16) exp_b.push_back(8'(c));
      tick();
    end
    b_tvalid = 1'b0; b_tdata = '0;
    repeat (16) exp_b.push_back('0);
    @(negedge clk);
    check("t5_ovf", b_ovf, 1);
    check("t5_locked", b_locked, 1);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!b_locked) begin
        t = cyc;
        break;
      end
    end
    check("t5_lock_drop", t - s, 115);
    check("t5_queue_drained", exp_b.size(), 0);
    check("t5_unf", b_unf, 1);
    check("final_a_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
